// File: rtl/pdm_decim.sv
// Third-order CIC decimator: 1-bit PDM at clk rate in, signed W-bit PCM out at clk/2**LOG2R.
// Integrators and combs wrap modulo 2**A by design; only the final scaled output saturates.
module pdm_decim #(
    parameter int W     = 16,
    parameter int LOG2R = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                pdm,
    output logic signed [W-1:0] pcm,
    output logic                valid
);

    localparam int A  = 3 * LOG2R + 2;
    localparam int SH = 3 * LOG2R - (W - 1);

    localparam logic signed [A-1:0]     YMAX   = {{(A - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [A-1:0]     YMIN   = {{(A - W + 1){1'b1}}, {(W - 1){1'b0}}};
    localparam logic        [LOG2R-1:0] PH_MAX = '1;

    logic                    s0_q, s0_d;
    logic                    s1_q, s1_d;
    logic signed [A-1:0]     i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    logic signed [A-1:0]     d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic signed [A-1:0]     c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic        [LOG2R-1:0] ph_q, ph_d;
    logic                    tick_q, tick_d;
    logic signed [W-1:0]     pcm_q, pcm_d;
    logic                    valid_q, valid_d;

    logic signed [A-1:0]     x;
    logic signed [A-1:0]     y;
    logic                    tick;

    always_comb begin
        x    = s1_q ? {{(A - 1){1'b0}}, 1'b1} : '1;
        tick = ena && (ph_q == PH_MAX);
        y    = c3_q >>> SH;

        s0_d    = pdm;
        s1_d    = s0_q;
        i1_d    = i1_q;
        i2_d    = i2_q;
        i3_d    = i3_q;
        ph_d    = ph_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        c3_d    = c3_q;
        tick_d  = tick;
        pcm_d   = pcm_q;
        valid_d = 1'b0;

        if (ena) begin
            i1_d = i1_q + x;
            i2_d = i2_q + i1_q;
            i3_d = i3_q + i2_q;
            ph_d = ph_q + LOG2R'(1);
        end

        // Combs form a pipeline: each stage consumes the previous tick's value of the stage before.
        if (tick) begin
            c1_d = i3_q - d1_q;
            d1_d = i3_q;
            c2_d = c1_q - d2_q;
            d2_d = c1_q;
            c3_d = c2_q - d3_q;
            d3_d = c2_q;
        end

        // Output update is keyed to the registered tick alone, so it completes even if ena drops.
        if (tick_q) begin
            valid_d = 1'b1;
            if (y > YMAX) begin
                pcm_d = {1'b0, {(W - 1){1'b1}}};
            end else if (y < YMIN) begin
                pcm_d = {1'b1, {(W - 1){1'b0}}};
            end else begin
                pcm_d = y[W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            i1_q    <= '0;
            i2_q    <= '0;
            i3_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            c3_q    <= '0;
            ph_q    <= '0;
            tick_q  <= 1'b0;
            pcm_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            i1_q    <= i1_d;
            i2_q    <= i2_d;
            i3_q    <= i3_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            c3_q    <= c3_d;
            ph_q    <= ph_d;
            tick_q  <= tick_d;
            pcm_q   <= pcm_d;
            valid_q <= valid_d;
        end
    end

    assign pcm   = pcm_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_pdm_decim.sv
// Directed bench for pdm_decim (W=16, LOG2R=6): transients, settled levels, stalls and resets.
// Expected transient codes are hand-derived from the closed form I3(e) = sum x(j)*C(e-j,2).
module tb_pdm_decim;

    logic               clk = 1'b0;
    logic               rst;
    logic               ena;
    logic               pdm;
    logic signed [15:0] pcm;
    logic               valid;

    int total = 0;
    int bad   = 0;
    int mode  = 0;
    int phase = 0;
    int c;
    int nv;

    int exp_one  [7] = '{0, 0, 4033, 25664, 32765, 32767, 32767};
    int exp_zero [6] = '{0, 0, -4964, -26781, -32768, -32768};

    pdm_decim #(
        .W     (16),
        .LOG2R (6)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .pdm   (pdm),
        .pcm   (pcm),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Pattern 0: all zeros, 1: all ones, 2: alternating, 3: 1,1,1,0 repeating.
    task automatic drive_bit();
        case (mode)
            0:       pdm = 1'b0;
            1:       pdm = 1'b1;
            2:       pdm = phase[0];
            default: pdm = ((phase % 4) != 3);
        endcase
        phase++;
    endtask

    task automatic step();
        @(negedge clk);
        drive_bit();
    endtask

    task automatic run(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (valid === 1'b1) seen++;
        end
    endtask

    task automatic wait_valid(output int cyc);
        bit found;
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < 400) begin
            step();
            cyc++;
            if (valid === 1'b1) found = 1'b1;
        end
    endtask

    task automatic do_reset(input int m);
        int dummy;
        rst   = 1'b1;
        mode  = m;
        phase = 0;
        run(3, dummy);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ena = 1'b1;
        pdm = 1'b0;
        #1;
        check("reset_pcm", pcm, 0);
        check("reset_valid", {31'd0, valid}, 0);

        // Constant ones: transient codes then saturated full scale, 64-cycle spacing.
        do_reset(1);
        for (int k = 0; k < 7; k++) begin
            wait_valid(c);
            check($sformatf("ones_gap%0d", k), c, (k == 0) ? 65 : 64);
            check($sformatf("ones_pcm%0d", k), pcm, exp_one[k]);
        end

        // ena low for 37 cycles mid-frame stretches the spacing to 101.
        run(20, nv);
        ena = 1'b0;
        run(37, nv);
        ena = 1'b1;
        wait_valid(c);
        check("stall_gap", 20 + 37 + c, 101);
        check("stall_pcm", pcm, 32767);

        // ena drops right after a tick: the pending update still lands.
        run(63, nv);
        ena = 1'b0;
        step();
        check("late_valid", {31'd0, valid}, 1);
        check("late_pcm", pcm, 32767);
        run(9, nv);
        check("frozen_novalid", nv, 0);
        ena = 1'b1;
        wait_valid(c);
        check("late_gap", 9 + c, 74);
        check("late_pcm2", pcm, 32767);

        // Asynchronous reset asserted while valid is high.
        wait_valid(c);
        check("pre_rst_gap", c, 64);
        #1 rst = 1'b1;
        #1;
        check("async_rst_pcm", pcm, 0);
        check("async_rst_valid", {31'd0, valid}, 0);
        run(3, nv);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_valid(c);
            check($sformatf("rerst_gap%0d", k), c, (k == 0) ? 65 : 64);
            check($sformatf("rerst_pcm%0d", k), pcm, exp_one[k]);
        end

        // Constant zeros: negative full scale without saturation artifacts.
        do_reset(0);
        for (int k = 0; k < 6; k++) begin
            wait_valid(c);
            check($sformatf("zeros_gap%0d", k), c, (k == 0) ? 65 : 64);
            check($sformatf("zeros_pcm%0d", k), pcm, exp_zero[k]);
        end

        // Alternating bits settle to exactly zero.
        do_reset(2);
        for (int k = 0; k < 8; k++) begin
            wait_valid(c);
            check($sformatf("alt_gap%0d", k), c, (k == 0) ? 65 : 64);
            if (k >= 5) check($sformatf("alt_pcm%0d", k), pcm, 0);
        end

        // 75% density settles to half of positive full scale.
        do_reset(3);
        for (int k = 0; k < 8; k++) begin
            wait_valid(c);
            check($sformatf("d75_gap%0d", k), c, (k == 0) ? 65 : 64);
            if (k >= 5) check($sformatf("d75_pcm%0d", k), pcm, 16384);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
